// File: rtl/mmio_bus_arbiter_pkg.sv
// Shared types and constants for the two-master MMIO bus arbiter.
package mmio_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      ABORT = 2'd2
   } arb_state_e;

   localparam logic [31:0] ABORT_RDATA = 32'hDEAD_BEEF;

   // Grant index: which master owns the shared slave port.
   localparam logic GNT_M0 = 1'b0;
   localparam logic GNT_M1 = 1'b1;

   function automatic logic [1:0] grant_onehot(input logic idx);
      return (idx == GNT_M1) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/mmio_bus_arbiter_if.sv
// Bus bundle for the arbiter: two requesting masters (m0 core, m1 debug) and the shared slave port.
interface mmio_bus_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] m0_address;
   logic [DATA_W-1:0] m0_writedata;
   logic              m0_write_n;
   logic              m0_read_n;
   logic [DATA_W-1:0] m0_readdata;
   logic              m0_waitrequest;

   logic [ADDR_W-1:0] m1_address;
   logic [DATA_W-1:0] m1_writedata;
   logic              m1_write_n;
   logic              m1_read_n;
   logic [DATA_W-1:0] m1_readdata;
   logic              m1_waitrequest;

   logic [ADDR_W-1:0] s_address;
   logic [DATA_W-1:0] s_writedata;
   logic              s_write_n;
   logic              s_read_n;
   logic [DATA_W-1:0] s_readdata;
   logic              s_waitrequest;

   // master: the arbiter's view (it masters the shared slave port)
   modport master (
      input  m0_address, m0_writedata, m0_write_n, m0_read_n,
      output m0_readdata, m0_waitrequest,
      input  m1_address, m1_writedata, m1_write_n, m1_read_n,
      output m1_readdata, m1_waitrequest,
      output s_address, s_writedata, s_write_n, s_read_n,
      input  s_readdata, s_waitrequest
   );

   // slave: the surrounding system's view (requesting masters plus the slave)
   modport slave (
      output m0_address, m0_writedata, m0_write_n, m0_read_n,
      input  m0_readdata, m0_waitrequest,
      output m1_address, m1_writedata, m1_write_n, m1_read_n,
      input  m1_readdata, m1_waitrequest,
      input  s_address, s_writedata, s_write_n, s_read_n,
      output s_readdata, s_waitrequest
   );
endinterface

// File: rtl/mmio_bus_arbiter.sv
// Round-robin arbiter between the core data port (m0) and debug port (m1) onto one MMIO slave,
// with a stall timeout that aborts the transfer and returns a poison read value.
module mmio_bus_arbiter
   import mmio_arb_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                clock,
   input  logic                reset,
   mmio_bus_arbiter_if.master  bus,
   output logic [1:0]          gnt,
   output logic                bus_err
);

   localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

   arb_state_e state_q, state_d;
   logic       grant_q, grant_d;
   logic       last_q, last_d;
   logic [7:0] stall_q, stall_d;

   logic              req0, req1, pick, sel_req;
   logic [ADDR_W-1:0] sel_address;
   logic [DATA_W-1:0] sel_writedata;
   logic              sel_write_n, sel_read_n;
   logic [7:0]        stall_inc;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= GNT_M0;
         last_q  <= GNT_M1;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         stall_q <= stall_d;
      end
   end

   always_comb begin
      req0 = ~bus.m0_read_n | ~bus.m0_write_n;
      req1 = ~bus.m1_read_n | ~bus.m1_write_n;
      // on contention the master not served last wins
      pick = (req0 & req1) ? ~last_q : (req1 ? GNT_M1 : GNT_M0);

      sel_address   = (grant_q == GNT_M1) ? bus.m1_address   : bus.m0_address;
      sel_writedata = (grant_q == GNT_M1) ? bus.m1_writedata : bus.m0_writedata;
      sel_write_n   = (grant_q == GNT_M1) ? bus.m1_write_n   : bus.m0_write_n;
      sel_read_n    = (grant_q == GNT_M1) ? bus.m1_read_n    : bus.m0_read_n;
      sel_req       = ~sel_read_n | ~sel_write_n;
      stall_inc     = (stall_q == '1) ? stall_q : stall_q + 8'd1;

      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      stall_d = stall_q;

      gnt                = '0;
      bus_err            = 1'b0;
      bus.s_address      = '0;
      bus.s_writedata    = '0;
      bus.s_write_n      = 1'b1;
      bus.s_read_n       = 1'b1;
      bus.m0_readdata    = '0;
      bus.m0_waitrequest = 1'b1;
      bus.m1_readdata    = '0;
      bus.m1_waitrequest = 1'b1;

      case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               state_d = BUSY;
               grant_d = pick;
               stall_d = '0;
            end
         end
         BUSY: begin
            gnt             = grant_onehot(grant_q);
            bus.s_address   = sel_address;
            bus.s_writedata = sel_writedata;
            bus.s_write_n   = sel_write_n;
            // both strobes low is treated as a write
            bus.s_read_n    = sel_read_n | ~sel_write_n;
            if (grant_q == GNT_M1) begin
               bus.m1_readdata    = bus.s_readdata;
               bus.m1_waitrequest = bus.s_waitrequest;
            end else begin
               bus.m0_readdata    = bus.s_readdata;
               bus.m0_waitrequest = bus.s_waitrequest;
            end
            if (!sel_req) begin
               state_d = IDLE;
            end else if (!bus.s_waitrequest) begin
               state_d = IDLE;
               last_d  = grant_q;
            end else begin
               stall_d = stall_inc;
               if (stall_inc >= TIMEOUT_LIM) state_d = ABORT;
            end
         end
         ABORT: begin
            gnt     = grant_onehot(grant_q);
            bus_err = 1'b1;
            if (grant_q == GNT_M1) begin
               bus.m1_readdata    = DATA_W'(ABORT_RDATA);
               bus.m1_waitrequest = 1'b0;
            end else begin
               bus.m0_readdata    = DATA_W'(ABORT_RDATA);
               bus.m0_waitrequest = 1'b0;
            end
            last_d  = grant_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: doc/mmio_bus_arbiter.md
MMIO_BUS_ARBITER -- requirements
Module: mmio_bus_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: data width of all read and write data ports.
REQ-002 Parameter ADDR_W, default 32: address width of all address ports.
REQ-003 Parameter TIMEOUT_CYC, default 255, legal range 2..255: number of consecutive slave-stall cycles before a transfer is aborted.
REQ-004 Ports `clock` and `reset`, inputs, 1 bit each: one clock; reset is synchronous and active-high.
REQ-005 m0_address (in, ADDR_W), m0_writedata (in, DATA_W), m0_write_n (in, 1), m0_read_n (in, 1): core data-port request; write_n and read_n are active-low.
REQ-006 m0_readdata (out, DATA_W) and m0_waitrequest (out, 1): core data-port response; waitrequest is active-high.
REQ-007 m1_address, m1_writedata, m1_write_n, m1_read_n, m1_readdata, m1_waitrequest: debug/JTAG master port, with the same directions and widths as the m0 port.
REQ-008 s_address (out, ADDR_W), s_writedata (out, DATA_W), s_write_n (out, 1), s_read_n (out, 1): shared slave-side request.
REQ-009 s_readdata (in, DATA_W) and s_waitrequest (in, 1): shared slave-side response.
REQ-010 gnt (out, 2): one-hot current grant; bit 0 is m0, bit 1 is m1.
REQ-011 bus_err (out, 1): one-cycle pulse when a transfer is aborted on timeout.

Function
REQ-012 Master i requests when ~mi_read_n | ~mi_write_n; if both strobes are low, the arbiter SHALL treat the request as a write and keep s_read_n high.
REQ-013 FSM states SHALL be IDLE, BUSY and ABORT.
REQ-014 IDLE: s_read_n = s_write_n = 1, s_address = 0, s_writedata = 0, gnt = 00, both mi_waitrequest = 1, both mi_readdata = 0.
REQ-015 IDLE to BUSY when any request is present; the grant register is set on that clock edge.
- Arbitration latency is 1 cycle: a request seen in cycle N is driven on the s_* side in cycle N+1.
REQ-016 Arbitration is round-robin via a last-grant bit (reset value m1, so m0 wins the first contention).
- Single requester: that requester is granted.
- Both requesting: grant goes to the master not served last.
REQ-017 BUSY: the granted master's address, writedata and strobes SHALL pass combinationally to the s_* side.
- s_readdata and s_waitrequest pass combinationally back to the granted master.
- The non-granted master sees waitrequest = 1 and readdata = 0.
REQ-018 BUSY, completion: in a cycle with s_waitrequest = 0 and the granted request still asserted, the transfer completes; next state is IDLE and last-grant is updated.
- Minimum transfer latency is 2 cycles; there are no back-to-back grants without an IDLE cycle.
REQ-019 BUSY, request withdrawn: if the granted master drops both strobes, next state is IDLE with no completion and last-grant unchanged.
REQ-020 Stall counter (8 bit) is cleared on entry to BUSY and increments each BUSY cycle with s_waitrequest = 1.
- When the counter reaches TIMEOUT_CYC, next state is ABORT.
- The count saturates and SHALL NOT wrap.
REQ-021 ABORT (exactly 1 cycle):
- s_* strobes deasserted (high).
- Granted master sees waitrequest = 0 and readdata = 32'hDEAD_BEEF.
- bus_err = 1.
- Last-grant is updated; next state is IDLE.
REQ-022 A new request arriving during BUSY or ABORT SHALL be held off with waitrequest = 1 and arbitrated in the next IDLE cycle.
REQ-023 gnt SHALL reflect the grant register in BUSY and ABORT, and be 00 in IDLE.

Reset
REQ-024 While reset is high at a clock edge: state goes to IDLE, gnt = 00, bus_err = 0, counter = 0, last-grant = m1.
- All s_* outputs and mi_* outputs take their IDLE values from REQ-014.
REQ-025 Reset asserted mid-transfer SHALL abandon the transfer silently, with no bus_err pulse and no completion signalled to either master.

Structure
REQ-026 Package mmio_arb_pkg SHALL hold:
- the state enumeration (IDLE, BUSY, ABORT);
- the abort readdata constant 32'hDEAD_BEEF;
- the grant-index constants.
REQ-027 Single flat module with no sub-modules; the round-robin pick and the stall counter are inline.

Verification
REQ-028 m0 read 0x108, slave waitrequest low immediately -> gnt = 01 in cycle N+1, m0_readdata = s_readdata and m0_waitrequest = 0 in N+1, IDLE in N+2.
REQ-029 m0 and m1 both write continuously from reset:
- grants alternate 01, 10, 01, 10, each grant separated by one IDLE cycle;
- s_writedata matches the granted master's data every time.
REQ-030 m1 read with s_waitrequest held high, TIMEOUT_CYC = 4 -> after 4 stall cycles, one ABORT cycle with m1_readdata = 32'hDEAD_BEEF, bus_err = 1 and s_read_n = 1; then IDLE.
REQ-031 m0 write with m0_read_n and m0_write_n both low -> s_write_n = 0 and s_read_n = 1.
REQ-032 m0 drops its strobe while the slave is stalled -> IDLE next cycle, bus_err = 0, and a pending m1 request is granted (gnt = 10) on the following cycle.
REQ-033 Reset pulsed during BUSY with a slave stall -> IDLE outputs in the next cycle, bus_err never asserted, and m0 wins the first post-reset contention.
